init_port_burst: RTL and testbench

INIT_PORT_BURST -- requirements
Module: init_port_burst

---
 rtl/init_port_burst_if.sv | 46 ++++
 rtl/init_port_burst.sv | 251 +++++++++++++++++++++++++
 tb/tb_init_port_burst.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/init_port_burst_if.sv
// Bundles the request, write/read beat, arbitration and serial bus signals of
// the burst initiator port.
//   master : the initiator's view (init_port_burst).
//   slave  : the environment's view (requester, arbiter and target together).
interface init_port_burst_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 4
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              done;
    logic              err;
    logic              arb_req;
    logic              arb_grant;
    logic              bus_data_out;
    logic              bus_data_out_valid;
    logic              bus_mode;
    logic              bus_rw;
    logic              bus_data_in;
    logic              bus_data_in_valid;
    logic              target_ack;
    logic              target_split;

    modport master (
        input  req_valid, req_rw, req_addr, req_len, wdata, wdata_valid, arb_grant,
               bus_data_in, bus_data_in_valid, target_ack, target_split,
        output req_ready, wdata_ready, rdata, rdata_valid, done, err, arb_req,
               bus_data_out, bus_data_out_valid, bus_mode, bus_rw
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_len, wdata, wdata_valid, arb_grant,
               bus_data_in, bus_data_in_valid, target_ack, target_split,
        input  req_ready, wdata_ready, rdata, rdata_valid, done, err, arb_req,
               bus_data_out, bus_data_out_valid, bus_mode, bus_rw
    );
endinterface

// File: rtl/init_port_burst.sv
// Burst initiator for a bit-serial shared bus. A captured request is arbitrated,
// its address is shifted out LSB first, then write beats are shifted out (and a
// target_ack awaited) or read beats are assembled from the serial RX line. A
// target split parks the transfer until the bus is re-granted, then resumes
// without resending the address.
// Ports:
//   clk, rst : clock, asynchronous active-high reset.
//   bus      : init_port_burst_if.master -- request handshake, write/read beats,
//              done/err pulses, arbitration and the serial bus lines.
module init_port_burst #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst,
    init_port_burst_if.master bus
);
    localparam int unsigned SHIFT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W   = $clog2(SHIFT_W) + 1;
    localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StArb, StAddr, StWdata, StWaitAck, StRdata, StSplit
    } state_e;

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;       // state to resume after a split
    logic               rw_q, rw_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [SHIFT_W-1:0] tx_q, tx_d;
    logic               tx_full_q, tx_full_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  rx_shift;
    logic [TO_W-1:0]    to_q, to_d;
    logic               resume_q, resume_d; // split released, re-arbitrating

    logic last_addr_bit, last_data_bit, last_beat, to_hit;

    assign last_addr_bit = (bit_q == CNT_W'(ADDR_W - 1));
    assign last_data_bit = (bit_q == CNT_W'(DATA_W - 1));
    assign last_beat     = (beat_q == len_q);
    assign to_hit        = (to_q == TO_W'(TIMEOUT - 1));
    // RX bits enter at the MSB so the first received bit ends up in bit 0.
    assign rx_shift      = {bus.bus_data_in, rx_q[DATA_W-1:1]};

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        tx_full_d = tx_full_q;
        rx_d      = rx_q;
        to_d      = to_q;
        resume_d  = resume_q;

        bus.req_ready          = 1'b0;
        bus.wdata_ready        = 1'b0;
        bus.rdata              = '0;
        bus.rdata_valid        = 1'b0;
        bus.done               = 1'b0;
        bus.err                = 1'b0;
        bus.arb_req            = 1'b0;
        bus.bus_data_out       = 1'b0;
        bus.bus_data_out_valid = 1'b0;
        bus.bus_mode           = 1'b0;
        bus.bus_rw             = (state_q != StIdle) ? rw_q : 1'b0;

        unique case (state_q)
            StIdle: begin
                // Held low while rst is asserted so every output reads 0 in reset.
                bus.req_ready = !rst;
                if (bus.req_valid) begin
                    rw_d      = bus.req_rw;
                    addr_d    = bus.req_addr;
                    len_d     = bus.req_len;
                    beat_d    = '0;
                    bit_d     = '0;
                    rx_d      = '0;
                    tx_full_d = 1'b0;
                    resume_d  = 1'b0;
                    state_d   = StArb;
                end
            end
            StArb: begin
                bus.arb_req = 1'b1;
                if (bus.arb_grant) begin
                    tx_d    = SHIFT_W'(addr_q);
                    bit_d   = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                bus.arb_req = 1'b1;
                if (!bus.arb_grant) begin
                    bus.err = 1'b1;
                    state_d = StIdle;
                end else begin
                    bus.bus_data_out_valid = 1'b1;
                    bus.bus_data_out       = tx_q[0];
                    tx_d                   = tx_q >> 1;
                    if (last_addr_bit) begin
                        bit_d     = '0;
                        tx_full_d = 1'b0;
                        state_d   = rw_q ? StWdata : StRdata;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StWdata: begin
                bus.arb_req  = 1'b1;
                bus.bus_mode = 1'b1;
                if (!bus.arb_grant) begin
                    bus.err   = 1'b1;
                    tx_full_d = 1'b0;
                    state_d   = StIdle;
                end else if (tx_full_q) begin
                    bus.bus_data_out_valid = 1'b1;
                    bus.bus_data_out       = tx_q[0];
                    tx_d                   = tx_q >> 1;
                    if (last_data_bit) begin
                        bit_d     = '0;
                        tx_full_d = 1'b0;
                        if (last_beat) begin
                            state_d = StWaitAck;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    // Shifter empty: take the next beat; it goes out from next cycle.
                    bus.wdata_ready = 1'b1;
                    if (bus.wdata_valid) begin
                        tx_d      = SHIFT_W'(bus.wdata);
                        tx_full_d = 1'b1;
                        bit_d     = '0;
                    end
                end
            end
            StWaitAck: begin
                bus.arb_req  = 1'b1;
                bus.bus_mode = 1'b1;
                if (bus.target_ack) begin
                    bus.done = 1'b1;
                    state_d  = StIdle;
                end else if (bus.target_split) begin
                    ret_d    = StWaitAck;
                    resume_d = 1'b0;
                    state_d  = StSplit;
                end else if (to_hit) begin
                    bus.err = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StRdata: begin
                bus.arb_req  = 1'b1;
                bus.bus_mode = 1'b1;
                if (bus.target_split) begin
                    ret_d    = StRdata;
                    resume_d = 1'b0;
                    state_d  = StSplit;
                end else if (bus.bus_data_in_valid) begin
                    to_d = '0;
                    rx_d = rx_shift;
                    if (last_data_bit) begin
                        bus.rdata_valid = 1'b1;
                        bus.rdata       = rx_shift;
                        bit_d           = '0;
                        if (last_beat) begin
                            bus.done = 1'b1;
                            state_d  = StIdle;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else if (to_hit) begin
                    bus.err = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StSplit: begin
                // Beat/bit counters and partial RX bits are left untouched here.
                to_d        = '0;
                bus.arb_req = resume_q;
                if (!resume_q) begin
                    if (!bus.target_split) begin
                        resume_d = 1'b1;
                    end
                end else if (bus.arb_grant) begin
                    resume_d = 1'b0;
                    state_d  = ret_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Every state change restarts the no-progress timer.
        if (state_d != state_q) begin
            to_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ret_q     <= StIdle;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            tx_full_q <= 1'b0;
            rx_q      <= '0;
            to_q      <= '0;
            resume_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            tx_full_q <= tx_full_d;
            rx_q      <= rx_d;
            to_q      <= to_d;
            resume_q  <= resume_d;
        end
    end
endmodule

// File: tb/tb_init_port_burst.sv
module tb_init_port_burst;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 4;
    localparam int unsigned TO = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    init_port_burst_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus_if ();

    init_port_burst #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .LEN_W  (LW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    logic [17:0] outs;
    assign outs = {bus_if.req_ready, bus_if.wdata_ready, bus_if.rdata, bus_if.rdata_valid,
                   bus_if.done, bus_if.err, bus_if.arb_req, bus_if.bus_data_out,
                   bus_if.bus_data_out_valid, bus_if.bus_mode, bus_if.bus_rw};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic            rw;
        logic [15:0]     addr;
        logic [3:0]      len;
        logic            ack_split;   // raise target_split together with target_ack
        logic [15:0]     exp_seq;     // address bits in send order, first bit = MSB
        logic [15:0][7:0] beats;      // stimulus: write beats / bytes the target sends
        logic [15:0][7:0] exp_beats;  // expected serial write beats / rdata values
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.req_valid         = 1'b0;
        bus_if.req_rw            = 1'b0;
        bus_if.req_addr          = '0;
        bus_if.req_len           = '0;
        bus_if.wdata             = '0;
        bus_if.wdata_valid       = 1'b0;
        bus_if.arb_grant         = 1'b0;
        bus_if.bus_data_in       = 1'b0;
        bus_if.bus_data_in_valid = 1'b0;
        bus_if.target_ack        = 1'b0;
        bus_if.target_split      = 1'b0;
    endtask

    // Request, grant and address phase; ends at the first data-phase cycle.
    task automatic do_addr(input vec_t v);
        logic [15:0] seq;
        logic        bad;
        logic        stray;
        bad   = 1'b0;
        stray = 1'b0;
        bus_if.req_valid = 1'b1;
        bus_if.req_rw    = v.rw;
        bus_if.req_addr  = v.addr;
        bus_if.req_len   = v.len;
        @(negedge clk);
        chk("req_ready in idle", bus_if.req_ready, 1);
        tick();
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.arb_grant = 1'b1;
        @(negedge clk);
        chk("arb_req in arb", bus_if.arb_req, 1);
        chk("bus_rw captured", bus_if.bus_rw, v.rw);
        tick();
        // Stray RX activity outside the read phase must be ignored.
        bus_if.bus_data_in_valid = v.rw;
        bus_if.bus_data_in       = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            seq[15-i] = bus_if.bus_data_out;
            bad   |= !bus_if.bus_data_out_valid | bus_if.bus_mode;
            stray |= bus_if.rdata_valid | bus_if.done | bus_if.err;
            tick();
        end
        bus_if.bus_data_in_valid = 1'b0;
        chk("addr bit sequence", seq, v.exp_seq);
        chk("addr valid=1 mode=0", bad, 0);
        chk("no strobes in addr", stray, 0);
    endtask

    // Feed write beats and collect the serial data bits; ends in WAIT_ACK cycle 1.
    task automatic wr_data(input vec_t v);
        logic [15:0][7:0] cap;
        int k, nbits, cyc, total;
        logic mode_bad;
        cap = '0; k = 0; nbits = 0; cyc = 0; mode_bad = 1'b0;
        total = 8 * (int'(v.len) + 1);
        while (nbits < total && cyc < 600) begin
            bus_if.wdata_valid = (k <= int'(v.len));
            if (k <= int'(v.len)) bus_if.wdata = v.beats[k];
            @(negedge clk);
            if (bus_if.wdata_ready && bus_if.wdata_valid) k++;
            if (bus_if.bus_data_out_valid) begin
                cap[nbits / 8][nbits % 8] = bus_if.bus_data_out;
                mode_bad |= !bus_if.bus_mode;
                nbits++;
            end
            tick();
            cyc++;
        end
        bus_if.wdata_valid = 1'b0;
        chk("wr data bit count", nbits, total);
        chk("wr data mode=1", mode_bad, 0);
        for (int b = 0; b <= int'(v.len); b++) chk("wr beat value", cap[b], v.exp_beats[b]);
    endtask

    task automatic wr_ack(input vec_t v);
        @(negedge clk);
        chk("wait_ack mode/arb/tx", {bus_if.bus_mode, bus_if.arb_req, bus_if.bus_data_out_valid,
                                     bus_if.done}, 4'b1100);
        tick();
        bus_if.target_ack   = 1'b1;
        bus_if.target_split = v.ack_split;
        @(negedge clk);
        chk("done on ack", {bus_if.done, bus_if.err}, 2'b10);
        tick();
        bus_if.target_ack   = 1'b0;
        bus_if.target_split = 1'b0;
        bus_if.arb_grant    = 1'b0;
        @(negedge clk);
        chk("idle after ack", {bus_if.req_ready, bus_if.arb_req, bus_if.done}, 3'b100);
        tick();
    endtask

    task automatic rd_data(input vec_t v);
        logic stray;
        stray = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            for (int i = 0; i < 8; i++) begin
                if (i == 3) begin
                    bus_if.bus_data_in_valid = 1'b0;
                    bus_if.bus_data_in       = 1'b1;
                    @(negedge clk);
                    stray |= bus_if.rdata_valid | bus_if.done | bus_if.err;
                    tick();
                end
                bus_if.bus_data_in_valid = 1'b1;
                bus_if.bus_data_in       = v.beats[b][i];
                @(negedge clk);
                if (i == 7) begin
                    chk("rd beat strobe", bus_if.rdata_valid, 1);
                    chk("rd beat data", bus_if.rdata, v.exp_beats[b]);
                    chk("rd done with strobe", bus_if.done, (b == int'(v.len)));
                end else begin
                    stray |= bus_if.rdata_valid | bus_if.done | bus_if.err;
                end
                tick();
            end
        end
        bus_if.bus_data_in_valid = 1'b0;
        bus_if.arb_grant         = 1'b0;
        chk("rd no stray strobes", stray, 0);
        @(negedge clk);
        chk("idle after read", {bus_if.req_ready, bus_if.arb_req, bus_if.rdata_valid}, 3'b100);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic flag;
        int   first_err;
        logic saw_done;

        vecs[0] = '0;
        vecs[0].rw = 1'b1; vecs[0].addr = 16'hA5C3; vecs[0].len = 4'd1;
        vecs[0].exp_seq = 16'b1100_0011_1010_0101;
        vecs[0].beats[0] = 8'h3C; vecs[0].beats[1] = 8'h81;
        vecs[0].exp_beats[0] = 8'h3C; vecs[0].exp_beats[1] = 8'h81;

        vecs[1] = '0;
        vecs[1].rw = 1'b0; vecs[1].addr = 16'h0010; vecs[1].len = 4'd2;
        vecs[1].exp_seq = 16'b0000_1000_0000_0000;
        vecs[1].beats[0] = 8'h11; vecs[1].beats[1] = 8'h22; vecs[1].beats[2] = 8'h33;
        vecs[1].exp_beats[0] = 8'h11; vecs[1].exp_beats[1] = 8'h22;
        vecs[1].exp_beats[2] = 8'h33;

        vecs[2] = '0;
        vecs[2].rw = 1'b1; vecs[2].addr = 16'h8001; vecs[2].len = 4'd0; vecs[2].ack_split = 1'b1;
        vecs[2].exp_seq = 16'b1000_0000_0000_0001;
        vecs[2].beats[0] = 8'hFF; vecs[2].exp_beats[0] = 8'hFF;

        vecs[3] = '0;
        vecs[3].rw = 1'b1; vecs[3].addr = 16'hFFFF; vecs[3].len = 4'd3;
        vecs[3].exp_seq = 16'hFFFF;
        vecs[3].beats[0] = 8'h00; vecs[3].beats[1] = 8'hA5;
        vecs[3].beats[2] = 8'h5A; vecs[3].beats[3] = 8'hFF;
        vecs[3].exp_beats[0] = 8'h00; vecs[3].exp_beats[1] = 8'hA5;
        vecs[3].exp_beats[2] = 8'h5A; vecs[3].exp_beats[3] = 8'hFF;

        // Maximum length: 16 beats, byte i = {i, ~i}.
        vecs[4] = '0;
        vecs[4].rw = 1'b0; vecs[4].addr = 16'h1234; vecs[4].len = 4'hF;
        vecs[4].exp_seq = 16'b0010_1100_0100_1000;
        for (int i = 0; i < 16; i++) begin
            vecs[4].beats[i]     = {4'(i), ~4'(i)};
            vecs[4].exp_beats[i] = {4'(i), ~4'(i)};
        end

        // Reset state.
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("outputs zero in reset", outs, 0);
        tick();
        chk("outputs zero in reset 2", outs, 0);
        rst = 1'b0;
        #1;
        chk("req_ready after release", bus_if.req_ready, 1);
        tick();

        // Table-driven transactions.
        for (int t = 0; t < 5; t++) begin
            do_addr(vecs[t]);
            if (vecs[t].rw) begin
                wr_data(vecs[t]);
                wr_ack(vecs[t]);
            end else begin
                rd_data(vecs[t]);
            end
        end

        // Split during a read after 12 RX bits, resume without re-addressing.
        v = '0;
        v.rw = 1'b0; v.addr = 16'h0F0F; v.len = 4'd1;
        v.exp_seq = 16'b1111_0000_1111_0000;
        v.beats[0] = 8'hC6; v.beats[1] = 8'h5A;
        do_addr(v);
        for (int i = 0; i < 12; i++) begin
            bus_if.bus_data_in_valid = 1'b1;
            bus_if.bus_data_in       = v.beats[i / 8][i % 8];
            @(negedge clk);
            if (i == 7) chk("split beat0 data", {bus_if.rdata_valid, bus_if.rdata}, {1'b1, 8'hC6});
            tick();
        end
        bus_if.bus_data_in_valid = 1'b0;
        bus_if.target_split      = 1'b1;
        bus_if.arb_grant         = 1'b0;
        @(negedge clk);
        chk("split entry no strobes", {bus_if.rdata_valid, bus_if.done, bus_if.err}, 0);
        tick();
        flag = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            flag |= bus_if.arb_req | bus_if.bus_data_out_valid;
            tick();
        end
        chk("arb_req low while split", flag, 0);
        bus_if.target_split = 1'b0;
        flag = 1'b1;
        for (int c = 0; c < 8 && !(flag && c > 0 && bus_if.arb_req); c++) begin
            @(negedge clk);
            if (bus_if.arb_req) flag = 1'b1;
            tick();
        end
        @(negedge clk);
        chk("re-arbitrate after split", bus_if.arb_req, 1);
        tick();
        flag = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            flag |= !bus_if.arb_req | bus_if.bus_data_out_valid;
            tick();
        end
        chk("arb_req held awaiting grant", flag, 0);
        bus_if.arb_grant = 1'b1;
        tick();
        flag = 1'b0;
        for (int i = 4; i < 8; i++) begin
            bus_if.bus_data_in_valid = 1'b1;
            bus_if.bus_data_in       = v.beats[1][i];
            @(negedge clk);
            flag |= bus_if.bus_data_out_valid | !bus_if.bus_mode;
            if (i == 7) begin
                chk("split beat1 data", {bus_if.rdata_valid, bus_if.rdata}, {1'b1, 8'h5A});
                chk("split done", bus_if.done, 1);
            end
            tick();
        end
        bus_if.bus_data_in_valid = 1'b0;
        bus_if.arb_grant         = 1'b0;
        chk("no address resent", flag, 0);

        // WAIT_ACK timeout.
        v = '0;
        v.rw = 1'b1; v.addr = 16'h0001; v.len = 4'd0;
        v.exp_seq = 16'b1000_0000_0000_0000;
        v.beats[0] = 8'h96; v.exp_beats[0] = 8'h96;
        do_addr(v);
        wr_data(v);
        first_err = 0;
        saw_done  = 1'b0;
        for (int c = 1; c <= 300 && first_err == 0; c++) begin
            @(negedge clk);
            saw_done |= bus_if.done;
            if (bus_if.err) first_err = c;
            tick();
        end
        chk("timeout err cycle", first_err, TO);
        chk("timeout no done", saw_done, 0);
        bus_if.arb_grant = 1'b0;
        @(negedge clk);
        chk("idle after timeout", {bus_if.req_ready, bus_if.arb_req, bus_if.err}, 3'b100);
        tick();

        // Grant drop at address bit 7.
        bus_if.req_valid = 1'b1;
        bus_if.req_rw    = 1'b1;
        bus_if.req_addr  = 16'hA5C3;
        bus_if.req_len   = 4'd0;
        tick();
        bus_if.req_valid = 1'b0;
        bus_if.arb_grant = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        bus_if.arb_grant = 1'b0;
        @(negedge clk);
        chk("grant drop err/tx", {bus_if.err, bus_if.bus_data_out_valid, bus_if.done}, 3'b100);
        tick();
        @(negedge clk);
        chk("idle after grant drop", {bus_if.req_ready, bus_if.arb_req, bus_if.err}, 3'b100);
        tick();

        // Reset in the middle of WDATA.
        v = '0;
        v.rw = 1'b1; v.addr = 16'h0002; v.len = 4'd1;
        v.exp_seq = 16'b0100_0000_0000_0000;
        do_addr(v);
        bus_if.wdata_valid = 1'b1;
        bus_if.wdata       = 8'h55;
        tick();
        bus_if.wdata_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("tx active before reset", bus_if.bus_data_out_valid, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("outputs zero on mid reset", outs, 0);
        flag = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            flag |= (outs != 0);
            tick();
        end
        chk("outputs stay zero in reset", flag, 0);
        rst = 1'b0;
        bus_if.arb_grant = 1'b0;
        #1;
        chk("idle after mid reset", {bus_if.req_ready, bus_if.arb_req, bus_if.done, bus_if.err},
            4'b1000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
